// File: rtl/loader_pkg.sv
// Shared types and sizing constants for the boot-time program loader.
// Optional trailing checksum is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int WCNT_W         = 16;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs little-endian stream bytes into 32-bit words; word_valid fires
// combinationally with the lane-3 byte, and the assembled word rides alongside it.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        take,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] partial;

  // Earlier bytes shift down so byte 0 ends up in bits [7:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      lane    <= 2'd0;
      partial <= 24'd0;
    end else if (take) begin
      lane    <= lane + 2'd1;
      partial <= {data, partial[23:8]};
    end
  end

  assign word_valid = take && (lane == 2'(BYTES_PER_WORD - 1));
  assign word       = {data, partial};

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes 32-bit words to instruction memory and holds
// the core in reset until the image is complete. Define LOADER_CHECKSUM_EN for XOR check.
module program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  localparam logic [WCNT_W:0] DEPTH_L = (WCNT_W + 1)'(IMEM_DEPTH);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t FRAME_END = ST_CSUM;
  logic [7:0] csum_acc;
`else
  localparam state_t FRAME_END = ST_DONE;
`endif

  state_t              state, state_nxt;
  logic [7:0]          len_lo;
  logic [WCNT_W-1:0]   n_words, word_index, hdr_n;
  logic                take, pack_take, word_valid, last_word;
  logic [31:0]         word;

  assign take      = in_valid && in_ready;
  assign pack_take = take && (state == ST_DATA);
  assign hdr_n     = {in_data, len_lo};
  assign last_word = (word_index == n_words - WCNT_W'(1));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .take       (pack_take),
    .data       (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HDR_LO;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    unique case (state)
      ST_HDR_LO: if (take) state_nxt = ST_HDR_HI;
      ST_HDR_HI: begin
        if (take) begin
          if ({1'b0, hdr_n} > DEPTH_L) state_nxt = ST_ERR;
          else if (hdr_n == '0)        state_nxt = FRAME_END;
          else                         state_nxt = ST_DATA;
        end
      end
      ST_DATA: if (word_valid && last_word) state_nxt = FRAME_END;
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: if (take) state_nxt = (in_data == csum_acc) ? ST_DONE : ST_ERR;
`endif
      ST_DONE: in_ready = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo     <= 8'd0;
      n_words    <= '0;
      word_index <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wdata <= 32'd0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_rst   <= 1'b1;
    end else begin
      imem_we <= word_valid;
      if (take && state == ST_HDR_LO) len_lo  <= in_data;
      if (take && state == ST_HDR_HI) n_words <= hdr_n;
      if (word_valid) begin
        imem_wdata <= word;
        imem_addr  <= {14'd0, word_index, 2'b00};
        word_index <= word_index + WCNT_W'(1);
      end
      if (state_nxt == ST_DONE) done  <= 1'b1;
      if (state_nxt == ST_ERR)  error <= 1'b1;
      // Released a cycle after done so the final write lands first.
      core_rst <= !done;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)            csum_acc <= 8'd0;
    else if (pack_take) csum_acc <= csum_acc ^ in_data;
  end
`endif

endmodule
